// File: rtl/instr_enc_pkg.sv
// ----------------------------------------------------------------------------
// instr_enc_pkg
// Shared definitions for the instruction encoder / imem loader:
//   - instr_class_e : descriptor class codes (6 and 7 are invalid)
//   - OPC_*         : RV32I major opcodes, same set as the control decoder
//   - NOP_WORD      : addi x0, x0, 0, written in place of an invalid class
//   - enc_state_e   : loader FSM state
// ----------------------------------------------------------------------------
package instr_enc_pkg;

    typedef enum logic [2:0] {
        CLS_LOAD   = 3'd0,
        CLS_STORE  = 3'd1,
        CLS_RTYPE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_IALU   = 3'd4,
        CLS_JAL    = 3'd5
    } instr_class_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } enc_state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// ----------------------------------------------------------------------------
// instr_encoder_if
// Bundles the descriptor input channel (valid/ready) and the instruction
// memory write channel (we/ready) of the encoder.
//   modport slave  : the encoder (consumes descriptors, drives imem writes)
//   modport master : the environment (produces descriptors, accepts writes)
// Parameter ADDR_W: instruction memory word-address width.
// ----------------------------------------------------------------------------
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_class;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic              in_funct7b5;
    logic [20:0]       in_imm;
    logic              in_last;

    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport slave (
        input  in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3,
               in_funct7b5, in_imm, in_last, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3,
               in_funct7b5, in_imm, in_last, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_pack.sv
// ----------------------------------------------------------------------------
// instr_pack
// Combinational field packer: descriptor class + fields -> RV32I word.
// Optional feature macro: ENC_RANGE_CHECK_EN (flag immediates that do not
// fit the target format; otherwise they are silently truncated).
// Ports:
//   class_i, rd_i, rs1_i, rs2_i, funct3_i, funct7b5_i, imm_i : descriptor
//   word_o      : encoded instruction (NOP for an invalid class)
//   range_err_o : immediate out of range for its format
//   class_err_o : class code 6 or 7
// ----------------------------------------------------------------------------
module instr_pack
    import instr_enc_pkg::*;
(
    input  logic [2:0]  class_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic [20:0] imm_i,
    output logic [31:0] word_o,
    output logic        range_err_o,
    output logic        class_err_o
);

    logic fits12;   // imm representable in 12-bit signed
    logic fits13;   // imm representable in 13-bit signed
    logic imm_even;

`ifdef ENC_RANGE_CHECK_EN
    // All bits above the format's sign bit must replicate it.
    assign fits12   = (imm_i[20:11] == {10{imm_i[11]}});
    assign fits13   = (imm_i[20:12] == {9{imm_i[12]}});
    assign imm_even = ~imm_i[0];
`else
    assign fits12   = 1'b1;
    assign fits13   = 1'b1;
    assign imm_even = 1'b1;
    // Bit 0 never reaches a B/J encoding when it is not checked.
    logic imm_lsb_unused;
    assign imm_lsb_unused = imm_i[0];
`endif

    // NOTE: every output gets a default before the case, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        word_o      = NOP_WORD;
        range_err_o = 1'b0;
        class_err_o = 1'b0;
        case (class_i)
            CLS_LOAD: begin
                word_o      = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
                range_err_o = ~fits12;
            end
            CLS_STORE: begin
                word_o      = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
                range_err_o = ~fits12;
            end
            CLS_RTYPE: begin
                word_o = {1'b0, funct7b5_i, 5'b00000, rs2_i, rs1_i, funct3_i, rd_i, OPC_RTYPE};
            end
            CLS_BRANCH: begin
                word_o      = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                               imm_i[4:1], imm_i[11], OPC_BRANCH};
                range_err_o = ~(fits13 & imm_even);
            end
            CLS_IALU: begin
                word_o      = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_IALU};
                range_err_o = ~fits12;
            end
            CLS_JAL: begin
                // A 21-bit operand always spans -2^20..2^20-1; only parity matters.
                word_o      = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
                range_err_o = ~imm_even;
            end
            default: begin
                class_err_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
// Streaming RV32I encoder and instruction-memory loader. Descriptors arrive
// on bus (valid/ready), are packed by instr_pack into a one-entry output
// register and written to consecutive word addresses from BASE_ADDR.
// Optional feature macro: ENC_RANGE_CHECK_EN (out-of-range immediates are
// handshaken but dropped and raise err).
// Parameters: ADDR_W (word-address width), BASE_ADDR (first address).
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : pulse, (re)starts a load from BASE_ADDR
//   bus         : descriptor input + imem write channel (slave modport)
//   done        : load complete, held until start
//   err         : sticky, invalid class / rejected immediate / overflow
//   ovf         : sticky, address space exhausted
//   instr_count : number of words written since start
// ----------------------------------------------------------------------------
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    instr_encoder_if.slave  bus,
    output logic            done,
    output logic            err,
    output logic            ovf,
    output logic [ADDR_W:0] instr_count
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    enc_state_e        state_q, state_d;
    logic              full_q,  full_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q,   err_d;
    logic              ovf_q,   ovf_d;

    logic [31:0] packed_word;
    logic        range_err;
    logic        class_err;
    logic        accept;
    logic        wr_done;

    instr_pack u_pack (
        .class_i     (bus.in_class),
        .rd_i        (bus.in_rd),
        .rs1_i       (bus.in_rs1),
        .rs2_i       (bus.in_rs2),
        .funct3_i    (bus.in_funct3),
        .funct7b5_i  (bus.in_funct7b5),
        .imm_i       (bus.in_imm),
        .word_o      (packed_word),
        .range_err_o (range_err),
        .class_err_o (class_err)
    );

    // While the pending word occupies the last address, refilling the
    // register on its write would leave the new word with no address, so
    // the input stays closed until the overflow takes the FSM to DONE.
    assign bus.in_ready = (state_q == ST_LOAD) &&
                          (!full_q || (bus.imem_ready && (addr_q != LAST_ADDR)));

    assign accept  = bus.in_valid && bus.in_ready;
    assign wr_done = full_q && bus.imem_ready;

    always_comb begin
        state_d = state_q;
        full_d  = full_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        ovf_d   = ovf_q;

        if (start) begin
            // Restart drops any pending word and clears the run status.
            state_d = ST_LOAD;
            full_d  = 1'b0;
            addr_d  = BASE;
            count_d = '0;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
        end else if (state_q == ST_LOAD || state_q == ST_DRAIN) begin
            if (wr_done) begin
                full_d  = 1'b0;
                count_d = count_q + (ADDR_W+1)'(1);
                if (addr_q == LAST_ADDR) begin
                    ovf_d   = 1'b1;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end

            if (accept) begin
                if (!range_err) begin
                    full_d  = 1'b1;
                    wdata_d = packed_word;
                end
                if (range_err || class_err) begin
                    err_d = 1'b1;
                end
                if (bus.in_last) begin
                    state_d = ST_DRAIN;
                end
            end

            // Leave DRAIN as soon as the register is, or is becoming, empty
            // so done rises the cycle after the final write.
            if (state_q == ST_DRAIN && (!full_q || wr_done)) begin
                state_d = ST_DONE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            full_q  <= 1'b0;
            wdata_q <= '0;
            addr_q  <= BASE;
            count_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            full_q  <= full_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.imem_we    = full_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign done           = (state_q == ST_DONE);
    assign err            = err_q;
    assign ovf            = ovf_q;
    assign instr_count    = count_q;

endmodule
